// File: rtl/ln_seq_pkg.sv
// Shared types and constants for the LINEALIZADOR_NORMALIZADOR sample sequencer.
package ln_seq_pkg;

  localparam int unsigned LnDataW  = 32;
  localparam int unsigned PairCntW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StPresent
  } seq_state_e;

endpackage

// File: rtl/ln_seq_watchdog.sv
// Watchdog for the WAIT phase: 16-bit cycle counter with clear/enable and a
// TIMEOUT compare that flags the last permitted wait cycle.
module ln_seq_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [15:0] cnt_q;

  // Cycle counter; clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // High during the final enabled cycle before the budget runs out.
  always_comb begin
    expire = en && (cnt_q == 16'(TIMEOUT - 1));
  end

endmodule

// File: rtl/ln_sample_sequencer.sv
// Feeds I/V sample pairs to the linearizer datapath, gathers both results and
// presents them downstream; a watchdog aborts hung transactions.
module ln_sample_sequencer
  import ln_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = LnDataW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                smp_valid,
  output logic                smp_ready,
  input  logic [DATA_W-1:0]   smp_i,
  input  logic [DATA_W-1:0]   smp_v,
  output logic                ln_begin_i,
  output logic                ln_begin_v,
  output logic [DATA_W-1:0]   ln_i,
  output logic [DATA_W-1:0]   ln_v,
  input  logic                ln_ack_i,
  input  logic                ln_ack_v,
  input  logic [DATA_W-1:0]   ln_result_i,
  input  logic [DATA_W-1:0]   ln_result_v,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_i,
  output logic [DATA_W-1:0]   out_v,
  output logic                busy,
  output logic                timeout_err,
  input  logic                clr_err,
  output logic [PairCntW-1:0] pair_cnt
);

  seq_state_e          state_q, state_d;
  logic [DATA_W-1:0]   ln_i_q, ln_i_d, ln_v_q, ln_v_d;
  logic [DATA_W-1:0]   out_i_q, out_i_d, out_v_q, out_v_d;
  logic                ack_i_q, ack_i_d, ack_v_q, ack_v_d;
  logic                err_q, err_d;
  logic                begin_q, begin_d;
  logic                out_valid_q, out_valid_d;
  logic [PairCntW-1:0] pair_cnt_q, pair_cnt_d;
  logic                wd_clr, wd_en, wd_expire;
  logic                ack_i_now, ack_v_now;

  ln_seq_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wd_clr),
    .en    (wd_en),
    .expire(wd_expire)
  );

  // Pair is complete if each flag is already set or its ACK arrives this cycle.
  always_comb begin
    ack_i_now = ack_i_q | ln_ack_i;
    ack_v_now = ack_v_q | ln_ack_v;
  end

  // Next-state logic for the FSM, datapath registers, error flag and counter.
  always_comb begin
    state_d     = state_q;
    ln_i_d      = ln_i_q;
    ln_v_d      = ln_v_q;
    out_i_d     = out_i_q;
    out_v_d     = out_v_q;
    ack_i_d     = ack_i_q;
    ack_v_d     = ack_v_q;
    err_d       = err_q;
    begin_d     = 1'b0;
    out_valid_d = 1'b0;
    pair_cnt_d  = pair_cnt_q;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;

    // A timeout below overrides this clear when both happen together.
    if (clr_err) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (smp_valid && !err_q) begin
          ln_i_d  = smp_i;
          ln_v_d  = smp_v;
          begin_d = 1'b1;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        ack_i_d = 1'b0;
        ack_v_d = 1'b0;
        wd_clr  = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        wd_en = 1'b1;
        // Only the first result per channel is kept.
        if (ln_ack_i && !ack_i_q) begin
          ack_i_d = 1'b1;
          out_i_d = ln_result_i;
        end
        if (ln_ack_v && !ack_v_q) begin
          ack_v_d = 1'b1;
          out_v_d = ln_result_v;
        end
        if (ack_i_now && ack_v_now) begin
          out_valid_d = 1'b1;
          state_d     = StPresent;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StPresent: begin
        if (out_ready) begin
          pair_cnt_d = pair_cnt_q + 1'b1;
          state_d    = StIdle;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ln_i_q      <= '0;
      ln_v_q      <= '0;
      out_i_q     <= '0;
      out_v_q     <= '0;
      ack_i_q     <= 1'b0;
      ack_v_q     <= 1'b0;
      err_q       <= 1'b0;
      begin_q     <= 1'b0;
      out_valid_q <= 1'b0;
      pair_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ln_i_q      <= ln_i_d;
      ln_v_q      <= ln_v_d;
      out_i_q     <= out_i_d;
      out_v_q     <= out_v_d;
      ack_i_q     <= ack_i_d;
      ack_v_q     <= ack_v_d;
      err_q       <= err_d;
      begin_q     <= begin_d;
      out_valid_q <= out_valid_d;
      pair_cnt_q  <= pair_cnt_d;
    end
  end

  // Outputs: everything registered except the state decodes.
  always_comb begin
    smp_ready   = (state_q == StIdle) && !err_q;
    busy        = (state_q != StIdle);
    ln_begin_i  = begin_q;
    ln_begin_v  = begin_q;
    ln_i        = ln_i_q;
    ln_v        = ln_v_q;
    out_valid   = out_valid_q;
    out_i       = out_i_q;
    out_v       = out_v_q;
    timeout_err = err_q;
    pair_cnt    = pair_cnt_q;
  end

endmodule

// File: tb/tb_ln_sample_sequencer.sv
// Directed table-driven bench for ln_sample_sequencer (TIMEOUT = 8).
module tb_ln_sample_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          smp_valid = 1'b0;
  logic          smp_ready;
  logic [DW-1:0] smp_i = '0, smp_v = '0;
  logic          ln_begin_i, ln_begin_v;
  logic [DW-1:0] ln_i, ln_v;
  logic          ln_ack_i = 1'b0, ln_ack_v = 1'b0;
  logic [DW-1:0] ln_result_i = '0, ln_result_v = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_i, out_v;
  logic          busy, timeout_err;
  logic          clr_err = 1'b0;
  logic [15:0]   pair_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  ln_sample_sequencer #(
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .smp_valid  (smp_valid),
    .smp_ready  (smp_ready),
    .smp_i      (smp_i),
    .smp_v      (smp_v),
    .ln_begin_i (ln_begin_i),
    .ln_begin_v (ln_begin_v),
    .ln_i       (ln_i),
    .ln_v       (ln_v),
    .ln_ack_i   (ln_ack_i),
    .ln_ack_v   (ln_ack_v),
    .ln_result_i(ln_result_i),
    .ln_result_v(ln_result_v),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_i      (out_i),
    .out_v      (out_v),
    .busy       (busy),
    .timeout_err(timeout_err),
    .clr_err    (clr_err),
    .pair_cnt   (pair_cnt)
  );

  // ack cycles are 1-based WAIT cycle numbers; 0 means never
  typedef struct {
    logic [31:0] s_i;
    logic [31:0] s_v;
    int          ack_i_cyc;
    logic [31:0] res_i;
    int          ack_v_cyc;
    logic [31:0] res_v;
    int          dup_cyc;
    logic [31:0] dup_res;
    int          ready_wait;
    int          exp_done;
    logic        exp_to;
    logic [31:0] exp_oi;
    logic [31:0] exp_ov;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t t, input string nm);
    int done;
    logic got_to;
    done   = 0;
    got_to = 1'b0;
    chk({nm, " smp_ready idle"}, 32'(smp_ready), 32'd1);
    smp_i     = t.s_i;
    smp_v     = t.s_v;
    smp_valid = 1'b1;
    @(posedge clk);
    #1 smp_valid = 1'b0;
    chk({nm, " begin_i"}, 32'(ln_begin_i), 32'd1);
    chk({nm, " begin_v"}, 32'(ln_begin_v), 32'd1);
    chk({nm, " ln_i"}, ln_i, t.s_i);
    chk({nm, " ln_v"}, ln_v, t.s_v);
    @(posedge clk);
    #1;
    chk({nm, " begin pulse ends"}, 32'(ln_begin_i | ln_begin_v), 32'd0);
    chk({nm, " busy in wait"}, 32'(busy), 32'd1);
    for (int w = 1; w <= 20; w++) begin
      ln_ack_i    = (w == t.ack_i_cyc) || (w == t.dup_cyc);
      ln_result_i = (w == t.dup_cyc) ? t.dup_res : ((w == t.ack_i_cyc) ? t.res_i : 32'h0);
      ln_ack_v    = (w == t.ack_v_cyc);
      ln_result_v = (w == t.ack_v_cyc) ? t.res_v : 32'h0;
      @(posedge clk);
      #1;
      ln_ack_i = 1'b0;
      ln_ack_v = 1'b0;
      if (out_valid || timeout_err) begin
        done   = w;
        got_to = timeout_err;
        break;
      end
    end
    chk({nm, " completion cycle"}, 32'(done), 32'(t.exp_done));
    chk({nm, " timeout flag"}, 32'(got_to), 32'(t.exp_to));
    if (t.exp_to) begin
      chk({nm, " no out_valid"}, 32'(out_valid), 32'd0);
      chk({nm, " idle after to"}, 32'(busy), 32'd0);
      chk({nm, " cnt unchanged"}, 32'(pair_cnt), 32'(exp_cnt));
      repeat (3) @(posedge clk);
      #1;
      chk({nm, " ready blocked"}, 32'(smp_ready), 32'd0);
      chk({nm, " err sticky"}, 32'(timeout_err), 32'd1);
      clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
      chk({nm, " err cleared"}, 32'(timeout_err), 32'd0);
      chk({nm, " ready restored"}, 32'(smp_ready), 32'd1);
    end else begin
      chk({nm, " out_i"}, out_i, t.exp_oi);
      chk({nm, " out_v"}, out_v, t.exp_ov);
      chk({nm, " ready low in present"}, 32'(smp_ready), 32'd0);
      for (int k = 0; k < t.ready_wait; k++) begin
        @(posedge clk);
        #1;
        chk({nm, " bp valid"}, 32'(out_valid), 32'd1);
        chk({nm, " bp out_i"}, out_i, t.exp_oi);
        chk({nm, " bp out_v"}, out_v, t.exp_ov);
        chk({nm, " bp smp_ready"}, 32'(smp_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      chk({nm, " valid drop"}, 32'(out_valid), 32'd0);
      chk({nm, " pair_cnt"}, 32'(pair_cnt), 32'(exp_cnt));
      chk({nm, " ready after hs"}, 32'(smp_ready), 32'd1);
      chk({nm, " ln_i held"}, ln_i, t.s_i);
    end
  endtask

  initial begin
    //             s_i           s_v           ai  res_i         av  res_v         dup dup_res       bp done to  exp_oi        exp_ov
    vecs[0] = '{32'hFD28E4FA, 32'hB0BCEE61, 3, 32'h3F800000, 7, 32'h40000000, 0, 32'h0,        0, 7, 1'b0, 32'h3F800000, 32'h40000000};
    vecs[1] = '{32'h12345678, 32'h9ABCDEF0, 1, 32'hC0000000, 1, 32'h3F000000, 0, 32'h0,        0, 1, 1'b0, 32'hC0000000, 32'h3F000000};
    vecs[2] = '{32'h0BADF00D, 32'h600DCAFE, 2, 32'h11111111, 5, 32'h33333333, 4, 32'h22222222, 0, 5, 1'b0, 32'h11111111, 32'h33333333};
    vecs[3] = '{32'hAAAA5555, 32'h5555AAAA, 2, 32'h3F400000, 3, 32'hBF800000, 0, 32'h0,       10, 3, 1'b0, 32'h3F400000, 32'hBF800000};
    vecs[4] = '{32'hDEADBEEF, 32'hCAFEF00D, 2, 32'h44444444, 0, 32'h0,        0, 32'h0,        0, 8, 1'b1, 32'h0,        32'h0};
    vecs[5] = '{32'h00000001, 32'h80000000, 4, 32'h7F800000, 1, 32'h00800000, 0, 32'h0,        0, 4, 1'b0, 32'h7F800000, 32'h00800000};
    vecs[6] = '{32'h3C23D70A, 32'h42C80000, 1, 32'h01020304, 8, 32'h05060708, 0, 32'h0,        0, 8, 1'b0, 32'h01020304, 32'h05060708};

    // Reset values
    #12;
    chk("rst smp_ready", 32'(smp_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst begin", 32'(ln_begin_i | ln_begin_v), 32'd0);
    chk("rst pair_cnt", 32'(pair_cnt), 32'd0);
    chk("rst ln_i", ln_i, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      @(posedge clk);
      #1;
    end

    // Reset in the middle of WAIT
    smp_i     = 32'h13579BDF;
    smp_v     = 32'h2468ACE0;
    smp_valid = 1'b1;
    @(posedge clk);
    #1 smp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid busy before rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst smp_ready", 32'(smp_ready), 32'd1);
    chk("mid rst pair_cnt", 32'(pair_cnt), 32'd0);
    chk("mid rst ln_i", ln_i, 32'h0);
    chk("mid rst ln_v", ln_v, 32'h0);
    chk("mid rst err", 32'(timeout_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ln_ack_i    = 1'b1;
    ln_ack_v    = 1'b1;
    ln_result_i = 32'h99999999;
    ln_result_v = 32'h88888888;
    @(posedge clk);
    #1;
    ln_ack_i = 1'b0;
    ln_ack_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("late ack valid", 32'(out_valid), 32'd0);
    chk("late ack out_i", out_i, 32'h0);
    chk("late ack pair_cnt", 32'(pair_cnt), 32'd0);

    // Counter wrap via preload
    @(negedge clk);
    dut.pair_cnt_q = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    @(posedge clk);
    #1;
    chk("preload cnt", 32'(pair_cnt), 32'h0000FFFF);
    run_vec(vecs[1], "wrap");
    chk("wrap to zero", 32'(pair_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
